// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: one-entry valid/ready dispatcher driving a 1-to-4 demux with per-channel delivery counters
module demux_dispatch_ctrl #(
  parameter int N = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_dest,
  input  logic             mode,
  input  logic [3:0]       ch_ready,
  output logic [N-1:0]     demux_in,
  output logic [1:0]       demux_select,
  output logic             demux_enable,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t           r_state, w_next;
  logic [N-1:0]     r_data;
  logic [1:0]       r_dest, r_rr, w_new_dest;
  logic [CNT_W-1:0] r_cnt [4];
  logic             w_xfer, w_accept;
  assign w_xfer       = (r_state == FULL) & ch_ready[r_dest];
  assign in_ready     = (r_state == EMPTY) | w_xfer;
  assign w_accept     = in_valid & in_ready;
  assign w_new_dest   = mode ? in_dest : r_rr;
  assign demux_enable = (r_state == FULL);
  assign demux_in     = r_data;
  assign demux_select = r_dest;
  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];
  // next state: a new accept always leaves us FULL, a lone delivery empties the slot
  always_comb begin
    w_next = w_accept ? FULL : (w_xfer ? EMPTY : r_state);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_next;
  end
  // holding register and round-robin pointer, loaded only on accept so held values never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_dest <= '0;
      r_rr   <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_dest <= w_new_dest;
      if (!mode) r_rr <= r_rr + 2'd1;
    end
  end
  // saturating delivery counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr)
          r_cnt[i] <= '0;
        else if (w_xfer && r_dest == 2'(i) && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end
endmodule
